reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
In-order retirement buffer for the out-of-order core. It allocates a 4-bit tag per issued instruction and drives the rename write (issue-side tag) into the register file. It collects results from the CDB and retires entries strictly in program order, producing the commit write and tag-release toward the register file. On a branch mispredict at commit it flushes itself and raises RoB_clear with the redirect PC.

Parameters:
DEPTH, 16, number of entries; fixed to 16 because tags are 4 bits
TAG_W, 4, tag width, log2(DEPTH)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; all state holds when low
issue_valid  input  1  decoder presents an instruction this cycle
issue_type  input  2  0=REG write, 1=STORE, 2=BRANCH (may also write rd, e.g. jal), 3=EXIT
issue_rd  input  5  destination register (0 = none)
issue_pred_jump  input  1  predictor decision for BRANCH
issue_alt_pc  input  32  PC to redirect to if prediction was wrong
issue_tag  output  4  tag assigned to the presented instruction (= tail)
full  output  1  count==16; issue is refused
rn_index  output  5  register file set_q_index_1 (rename at issue)
rn_val  output  32  register file set_q_val_1, {28'b0, tag}
cdb_valid  input  1  result broadcast valid
cdb_tag  input  4  tag of the broadcast result
cdb_val  input  32  result value
cdb_jump  input  1  actual branch outcome
query_tag_1, query_tag_2  input  4  operand tags from register file q
query_ready_1, query_ready_2  output  1  that entry's value is available
query_val_1, query_val_2  output  32  that entry's value
commit_reg  output  5  register file set_reg
commit_val  output  32  register file set_val
commit_q_index  output  5  register file set_q_index_2
commit_q_val  output  32  register file set_q_val_2, {28'b0, committed tag}
store_commit  output  1  one-cycle pulse: head STORE retired
store_tag  output  4  tag of the retired store
RoB_clear  output  1  one-cycle flush pulse
clear_pc  output  32  redirect PC, valid while RoB_clear=1
halted  output  1  sticky; EXIT has retired

Behaviour:
- Storage: circular buffer; head, tail 4-bit wrap 15->0; count 5-bit. Per entry: busy, ready, type, rd, val, jump, pred_jump, alt_pc.
- Reset (rst_in=1 at posedge): head=tail=count=0; all busy=0; commit_reg=commit_q_index=0, commit_val=commit_q_val=0, store_commit=0, RoB_clear=0, clear_pc=0, halted=0. Reset overrides rdy_in.
- rdy_in=0: no state change; registered outputs hold.
- Issue (combinational): accept = issue_valid & !full & !RoB_clear & !halted. issue_tag=tail always. rn_index = issue_rd if accept and type in {REG, BRANCH}, else 0. rn_val = {28'b0, tail}.
- Issue (posedge): on accept, write entry[tail], busy=1, ready = (type==EXIT); tail++.
- CDB: on cdb_valid & busy[cdb_tag], set ready=1, val=cdb_val, jump=cdb_jump. A broadcast to a non-busy tag is ignored.
- Query: combinational. ready = entry.ready, or cdb_valid & cdb_tag==query_tag (bypass). val = cdb_val on bypass, else entry.val.
- Commit: at a posedge where busy[head] & ready[head] & !RoB_clear, retire head: busy=0, head++.
- Commit outputs are registered and valid in the next cycle only; otherwise they are 0.
  - REG, or BRANCH with rd!=0: commit_reg = commit_q_index = rd; commit_val = val; commit_q_val = {28'b0, head}.
  - STORE: store_commit=1, store_tag=head.
  - EXIT: halted<=1.
  - BRANCH with jump != pred_jump: RoB_clear<=1 and clear_pc<=alt_pc. At the same edge, head=tail=count=0 and all busy=0. Issue and commit are suppressed while RoB_clear=1.
- Retire rate: at most 1 per cycle. Issue rate: at most 1 per cycle. count += accept - retire.
- full uses the pre-commit count, so there is no same-cycle issue into a slot being freed.
- Issue and commit of the same rd in one cycle: both are driven; the register file's rename wins.

Test Plan:
- Reset, issue REG rd=5 -> issue_tag=0, rn_index=5, rn_val=0. CDB tag0 val=0x1234 -> next cycle commit_reg=5, commit_val=0x1234, commit_q_index=5, commit_q_val=0; one cycle later all commit outputs are 0.
- Issue 16 REG, no CDB -> full=1 after the 16th; 17th issue_valid gives rn_index=0 and tail unchanged. Complete tag0 -> retire, then full=0; the next issue gets tag 0 (wrap).
- Out-of-order CDB: issue tags 0,1,2; complete 2, then 1, then 0 -> commits in order 0,1,2 on three consecutive cycles.
- BRANCH pred_jump=0, alt_pc=0x100, followed by 2 REG; CDB jump=1 -> RoB_clear=1, clear_pc=0x100 for one cycle; count=0; the next issue gets tag 0; no commit of the younger entries.
- Query bypass: query_tag_1=3 with cdb_valid, cdb_tag=3, cdb_val=0xAB in the same cycle -> query_ready_1=1, query_val_1=0xAB.
- rdy_in=0 for 3 cycles with a ready head -> no retire and outputs hold; resumes retiring on rdy_in=1.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: core-side bundle (issue, rename, CDB, operand query, commit) between core (master) and reorder buffer (slave)
interface reorder_buffer_if;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic        issue_pred_jump;
  logic [31:0] issue_alt_pc;
  logic [3:0]  issue_tag;
  logic        full;
  logic [4:0]  rn_index;
  logic [31:0] rn_val;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        cdb_jump;
  logic [3:0]  query_tag_1, query_tag_2;
  logic        query_ready_1, query_ready_2;
  logic [31:0] query_val_1, query_val_2;
  logic [4:0]  commit_reg;
  logic [31:0] commit_val;
  logic [4:0]  commit_q_index;
  logic [31:0] commit_q_val;
  logic        store_commit;
  logic [3:0]  store_tag;
  logic        RoB_clear;
  logic [31:0] clear_pc;
  logic        halted;
  modport master (
    output issue_valid, issue_type, issue_rd, issue_pred_jump, issue_alt_pc,
           cdb_valid, cdb_tag, cdb_val, cdb_jump, query_tag_1, query_tag_2,
    input  issue_tag, full, rn_index, rn_val, query_ready_1, query_ready_2,
           query_val_1, query_val_2, commit_reg, commit_val, commit_q_index,
           commit_q_val, store_commit, store_tag, RoB_clear, clear_pc, halted
  );
  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pred_jump, issue_alt_pc,
           cdb_valid, cdb_tag, cdb_val, cdb_jump, query_tag_1, query_tag_2,
    output issue_tag, full, rn_index, rn_val, query_ready_1, query_ready_2,
           query_val_1, query_val_2, commit_reg, commit_val, commit_q_index,
           commit_q_val, store_commit, store_tag, RoB_clear, clear_pc, halted
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry in-order retirement buffer; ports clk_in/rst_in/rdy_in plus rob (issue+rename, CDB capture, operand query, registered commit/store/flush/halt)
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input logic              clk_in,
  input logic              rst_in,
  input logic              rdy_in,
  reorder_buffer_if.slave  rob
);
  localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BRANCH = 2'd2, T_EXIT = 2'd3;
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic [DEPTH-1:0] busy, ready, jump, pred;
  logic [1:0]       typ    [DEPTH];
  logic [4:0]       rd     [DEPTH];
  logic [31:0]      val    [DEPTH];
  logic [31:0]      alt_pc [DEPTH];
  logic accept, retire, mispredict, writes_rd;
  assign rob.full       = count == (TAG_W+1)'(DEPTH);
  assign accept         = rob.issue_valid & ~rob.full & ~rob.RoB_clear & ~rob.halted;
  assign retire         = busy[head] & ready[head] & ~rob.RoB_clear;
  assign mispredict     = retire && typ[head] == T_BRANCH && jump[head] != pred[head];
  assign writes_rd      = typ[head] == T_REG || (typ[head] == T_BRANCH && rd[head] != 5'd0);
  assign rob.issue_tag  = tail;
  assign rob.rn_index   = accept && (rob.issue_type == T_REG || rob.issue_type == T_BRANCH) ? rob.issue_rd : 5'd0;
  assign rob.rn_val     = {{(32-TAG_W){1'b0}}, tail};
  // A result on the CDB this cycle is forwarded before it lands in the entry
  assign rob.query_ready_1 = ready[rob.query_tag_1] | (rob.cdb_valid & rob.cdb_tag == rob.query_tag_1);
  assign rob.query_ready_2 = ready[rob.query_tag_2] | (rob.cdb_valid & rob.cdb_tag == rob.query_tag_2);
  assign rob.query_val_1   = rob.cdb_valid && rob.cdb_tag == rob.query_tag_1 ? rob.cdb_val : val[rob.query_tag_1];
  assign rob.query_val_2   = rob.cdb_valid && rob.cdb_tag == rob.query_tag_2 ? rob.cdb_val : val[rob.query_tag_2];
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      busy               <= '0;
      ready              <= '0;
      rob.commit_reg     <= '0;
      rob.commit_val     <= '0;
      rob.commit_q_index <= '0;
      rob.commit_q_val   <= '0;
      rob.store_commit   <= 1'b0;
      rob.store_tag      <= '0;
      rob.RoB_clear      <= 1'b0;
      rob.clear_pc       <= '0;
      rob.halted         <= 1'b0;
    end else if (rdy_in) begin
      rob.commit_reg     <= retire && writes_rd ? rd[head] : 5'd0;
      rob.commit_q_index <= retire && writes_rd ? rd[head] : 5'd0;
      rob.commit_val     <= retire && writes_rd ? val[head] : 32'd0;
      rob.commit_q_val   <= retire && writes_rd ? {{(32-TAG_W){1'b0}}, head} : 32'd0;
      rob.store_commit   <= retire && typ[head] == T_STORE;
      rob.store_tag      <= retire && typ[head] == T_STORE ? head : '0;
      rob.RoB_clear      <= mispredict;
      if (mispredict) rob.clear_pc <= alt_pc[head];
      if (retire && typ[head] == T_EXIT) rob.halted <= 1'b1;
      if (accept) begin
        busy[tail]   <= 1'b1;
        ready[tail]  <= rob.issue_type == T_EXIT;
        typ[tail]    <= rob.issue_type;
        rd[tail]     <= rob.issue_rd;
        pred[tail]   <= rob.issue_pred_jump;
        alt_pc[tail] <= rob.issue_alt_pc;
      end
      // busy[tail] is never set while accepting, so this cannot collide with the issue write
      if (rob.cdb_valid && busy[rob.cdb_tag]) begin
        ready[rob.cdb_tag] <= 1'b1;
        val[rob.cdb_tag]   <= rob.cdb_val;
        jump[rob.cdb_tag]  <= rob.cdb_jump;
      end
      if (retire) busy[head] <= 1'b0;
      // A flush discards everything younger, including anything issued at this edge
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
      end else begin
        head  <= head + TAG_W'(retire);
        tail  <= tail + TAG_W'(accept);
        count <= count + (TAG_W+1)'(accept) - (TAG_W+1)'(retire);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  int pass = 0, total = 0;
  reorder_buffer_if rob();
  reorder_buffer dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob(rob));
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rob.issue_valid = 0; rob.issue_type = 0; rob.issue_rd = 0; rob.issue_pred_jump = 0; rob.issue_alt_pc = 0;
    rob.cdb_valid = 0; rob.cdb_tag = 0; rob.cdb_val = 0; rob.cdb_jump = 0;
    rob.query_tag_1 = 0; rob.query_tag_2 = 0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] r, input logic p, input logic [31:0] a);
    rob.issue_valid = 1; rob.issue_type = t; rob.issue_rd = r; rob.issue_pred_jump = p; rob.issue_alt_pc = a;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic j);
    rob.cdb_valid = 1; rob.cdb_tag = t; rob.cdb_val = v; rob.cdb_jump = j;
  endtask

  task automatic do_reset();
    idle(); rdy = 1; rst = 1;
    cyc(); cyc();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rob.full !== 1'b0) $display("FAIL reset_full got %0b exp 0", rob.full); else pass++;
    total++; if (rob.issue_tag !== 4'd0) $display("FAIL reset_tag got %0d exp 0", rob.issue_tag); else pass++;
    total++; if (rob.commit_reg !== 5'd0 || rob.commit_val !== 32'd0) $display("FAIL reset_commit got %0d/%0h exp 0/0", rob.commit_reg, rob.commit_val); else pass++;
    total++; if (rob.RoB_clear !== 1'b0 || rob.clear_pc !== 32'd0) $display("FAIL reset_clear got %0b/%0h exp 0/0", rob.RoB_clear, rob.clear_pc); else pass++;
    total++; if (rob.halted !== 1'b0 || rob.store_commit !== 1'b0) $display("FAIL reset_halt_store got %0b/%0b exp 0/0", rob.halted, rob.store_commit); else pass++;
  endtask

  task automatic test_basic();
    do_reset();
    issue(0, 5, 0, 0); #1;
    total++; if (rob.issue_tag !== 4'd0 || rob.rn_index !== 5'd5 || rob.rn_val !== 32'd0) $display("FAIL basic_rename got tag %0d idx %0d val %0h exp 0 5 0", rob.issue_tag, rob.rn_index, rob.rn_val); else pass++;
    cyc();
    idle(); cdb(0, 32'h1234, 0);
    cyc();
    idle();
    total++; if (rob.commit_reg !== 5'd0) $display("FAIL basic_early got %0d exp 0", rob.commit_reg); else pass++;
    cyc();
    total++; if (rob.commit_reg !== 5'd5 || rob.commit_q_index !== 5'd5) $display("FAIL basic_commit_reg got %0d/%0d exp 5/5", rob.commit_reg, rob.commit_q_index); else pass++;
    total++; if (rob.commit_val !== 32'h1234 || rob.commit_q_val !== 32'd0) $display("FAIL basic_commit_val got %0h/%0h exp 1234/0", rob.commit_val, rob.commit_q_val); else pass++;
    cyc();
    total++; if (rob.commit_reg !== 5'd0 || rob.commit_val !== 32'd0 || rob.commit_q_index !== 5'd0) $display("FAIL basic_clear got %0d/%0h/%0d exp 0/0/0", rob.commit_reg, rob.commit_val, rob.commit_q_index); else pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(0, 5'(i + 1), 0, 0); #1;
      total++; if (rob.issue_tag !== 4'(i) || rob.full !== 1'b0) $display("FAIL full_fill%0d got tag %0d full %0b exp %0d 0", i, rob.issue_tag, rob.full, i); else pass++;
      cyc();
    end
    total++; if (rob.full !== 1'b1 || rob.rn_index !== 5'd0) $display("FAIL full_set got full %0b idx %0d exp 1 0", rob.full, rob.rn_index); else pass++;
    cyc();
    total++; if (rob.issue_tag !== 4'd0 || rob.full !== 1'b1) $display("FAIL full_refuse got tag %0d full %0b exp 0 1", rob.issue_tag, rob.full); else pass++;
    idle(); cdb(0, 32'h7, 0);
    cyc();
    idle();
    cyc();
    total++; if (rob.full !== 1'b0 || rob.commit_reg !== 5'd1) $display("FAIL full_retire got full %0b reg %0d exp 0 1", rob.full, rob.commit_reg); else pass++;
    issue(0, 9, 0, 0); #1;
    total++; if (rob.issue_tag !== 4'd0 || rob.rn_index !== 5'd9) $display("FAIL full_wrap got tag %0d idx %0d exp 0 9", rob.issue_tag, rob.rn_index); else pass++;
    cyc();
    total++; if (rob.full !== 1'b1) $display("FAIL full_refill got %0b exp 1", rob.full); else pass++;
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(0, 5'(10 + i), 0, 0);
      cyc();
    end
    idle();
    for (int i = 2; i >= 0; i--) begin
      cdb(4'(i), 32'h100 + 32'(i), 0);
      cyc();
      total++; if (rob.commit_reg !== 5'd0) $display("FAIL ooo_early%0d got %0d exp 0", i, rob.commit_reg); else pass++;
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (rob.commit_reg !== 5'(10 + i) || rob.commit_val !== 32'h100 + 32'(i) || rob.commit_q_val !== 32'(i)) $display("FAIL ooo_commit%0d got %0d/%0h/%0d exp %0d/%0h/%0d", i, rob.commit_reg, rob.commit_val, rob.commit_q_val, 10 + i, 32'h100 + i, i); else pass++;
    end
    cyc();
    total++; if (rob.commit_reg !== 5'd0) $display("FAIL ooo_done got %0d exp 0", rob.commit_reg); else pass++;
  endtask

  task automatic test_mispredict();
    do_reset();
    issue(2, 0, 0, 32'h100); cyc();
    issue(0, 3, 0, 0); cyc();
    issue(0, 4, 0, 0); cdb(1, 32'h33, 0); cyc();
    idle(); cdb(0, 0, 1); cyc();
    idle(); cyc();
    total++; if (rob.RoB_clear !== 1'b1 || rob.clear_pc !== 32'h100) $display("FAIL mp_clear got %0b/%0h exp 1/100", rob.RoB_clear, rob.clear_pc); else pass++;
    total++; if (rob.commit_reg !== 5'd0) $display("FAIL mp_branch_reg got %0d exp 0", rob.commit_reg); else pass++;
    issue(0, 7, 0, 0); #1;
    total++; if (rob.rn_index !== 5'd0) $display("FAIL mp_issue_blocked got %0d exp 0", rob.rn_index); else pass++;
    cyc();
    total++; if (rob.RoB_clear !== 1'b0 || rob.commit_reg !== 5'd0) $display("FAIL mp_pulse got %0b/%0d exp 0/0", rob.RoB_clear, rob.commit_reg); else pass++;
    total++; if (rob.issue_tag !== 4'd0 || rob.rn_index !== 5'd7 || rob.full !== 1'b0) $display("FAIL mp_restart got tag %0d idx %0d full %0b exp 0 7 0", rob.issue_tag, rob.rn_index, rob.full); else pass++;
    cyc();
    idle();
    cyc();
    total++; if (rob.commit_reg !== 5'd0 || rob.issue_tag !== 4'd1) $display("FAIL mp_no_young got reg %0d tag %0d exp 0 1", rob.commit_reg, rob.issue_tag); else pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(0, 5'(i + 1), 0, 0);
      cyc();
    end
    idle();
    rob.query_tag_1 = 3; rob.query_tag_2 = 2; cdb(3, 32'hAB, 0); #1;
    total++; if (rob.query_ready_1 !== 1'b1 || rob.query_val_1 !== 32'hAB) $display("FAIL byp_q1 got %0b/%0h exp 1/ab", rob.query_ready_1, rob.query_val_1); else pass++;
    total++; if (rob.query_ready_2 !== 1'b0) $display("FAIL byp_q2 got %0b exp 0", rob.query_ready_2); else pass++;
    cyc();
    rob.cdb_valid = 0; rob.cdb_val = 0; #1;
    total++; if (rob.query_ready_1 !== 1'b1 || rob.query_val_1 !== 32'hAB) $display("FAIL byp_stored got %0b/%0h exp 1/ab", rob.query_ready_1, rob.query_val_1); else pass++;
  endtask

  task automatic test_rdy_hold();
    do_reset();
    issue(0, 9, 0, 0); cyc();
    issue(0, 10, 0, 0); cdb(0, 32'h55, 0); cyc();
    idle(); cdb(1, 32'h66, 0); cyc();
    idle();
    total++; if (rob.commit_reg !== 5'd9 || rob.commit_val !== 32'h55) $display("FAIL rdy_first got %0d/%0h exp 9/55", rob.commit_reg, rob.commit_val); else pass++;
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (rob.commit_reg !== 5'd9 || rob.commit_val !== 32'h55) $display("FAIL rdy_hold%0d got %0d/%0h exp 9/55", i, rob.commit_reg, rob.commit_val); else pass++;
    end
    rdy = 1;
    cyc();
    total++; if (rob.commit_reg !== 5'd10 || rob.commit_val !== 32'h66 || rob.commit_q_val !== 32'd1) $display("FAIL rdy_resume got %0d/%0h/%0d exp 10/66/1", rob.commit_reg, rob.commit_val, rob.commit_q_val); else pass++;
  endtask

  task automatic test_store_exit();
    do_reset();
    issue(1, 0, 0, 0); cyc();
    issue(3, 0, 0, 0); cdb(0, 0, 0); cyc();
    idle(); cyc();
    total++; if (rob.store_commit !== 1'b1 || rob.store_tag !== 4'd0 || rob.commit_reg !== 5'd0) $display("FAIL store_commit got %0b/%0d/%0d exp 1/0/0", rob.store_commit, rob.store_tag, rob.commit_reg); else pass++;
    cyc();
    total++; if (rob.halted !== 1'b1 || rob.store_commit !== 1'b0) $display("FAIL exit_halt got %0b/%0b exp 1/0", rob.halted, rob.store_commit); else pass++;
    issue(0, 6, 0, 0); #1;
    total++; if (rob.rn_index !== 5'd0) $display("FAIL exit_block got %0d exp 0", rob.rn_index); else pass++;
    cyc();
    total++; if (rob.halted !== 1'b1 || rob.issue_tag !== 4'd2) $display("FAIL exit_sticky got %0b/%0d exp 1/2", rob.halted, rob.issue_tag); else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_out_of_order();
    test_mispredict();
    test_bypass();
    test_rdy_hold();
    test_store_exit();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
